cam_capture: RTL



---
 rtl/cam_capture_if.sv | 28 ++
 rtl/cam_capture.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cam_capture_if.sv
// cam_capture_if: camera sampling inputs plus the frame-buffer write port
// driven by the capture stage.
//   master : the capture stage (samples the camera, drives the buffer write port)
//   slave  : the environment (drives the camera signals, observes the write port)
interface cam_capture_if #(
  parameter int AW = 15,
  parameter int DW = 12
);
  logic          init;
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic          px_wr;
  logic          done;
  logic          overflow;

  modport master (
    input  init, vsync, href, px_data,
    output mem_px_addr, mem_px_data, px_wr, done, overflow
  );

  modport slave (
    output init, vsync, href, px_data,
    input  mem_px_addr, mem_px_data, px_wr, done, overflow
  );
endinterface

// File: rtl/cam_capture.sv
// cam_capture: OV7670 QQVGA RGB565 capture stage. Pairs camera bytes into
// pixels, reduces them to RGB444 and writes them into the frame buffer at
// row*IMG_W + col. Capture always begins at a vsync falling edge so a frame is
// never entered half-way through.
// Build option: define CAM_TESTPAT_EN to replace the camera pixels with eight
// vertical colour bars (addressing and strobes unchanged).
module cam_capture #(
  parameter int AW    = 15,
  parameter int DW    = 12,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic          clk,
  input  logic          rst,
  cam_capture_if.master cam
);

  // One spare bit so the counters can sit past the stored image and flag overflow.
  localparam int COL_W = $clog2(IMG_W) + 1;
  localparam int ROW_W = $clog2(IMG_H) + 1;
  localparam int BAR_W = IMG_W / 8;

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE} state_t;

  state_t          state;
  logic            vsync_q;
  logic            href_q;
  logic            phase;
  logic [6:0]      byte1;   // only the R[4:1] and G[5:3] bits of the first byte are kept
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic            wr_q;
  logic            done_q;
  logic            ovf_q;

  logic vsync_rise;
  logic vsync_fall;
  logic href_fall;
  logic px_in_image;

  assign vsync_rise  = cam.vsync & ~vsync_q;
  assign vsync_fall  = ~cam.vsync & vsync_q;
  assign href_fall   = ~cam.href & href_q;
  assign px_in_image = (col < COL_W'(IMG_W)) && (row < ROW_W'(IMG_H));

`ifdef CAM_TESTPAT_EN
  // Vertical colour bars indexed by column.
  function automatic logic [11:0] pixel_value(logic [COL_W-1:0] c);
    logic [2:0] idx;
    idx = 3'(int'(c) / BAR_W);
    case (idx)
      3'd0:    return 12'hFFF;
      3'd1:    return 12'hFF0;
      3'd2:    return 12'h0FF;
      3'd3:    return 12'h0F0;
      3'd4:    return 12'hF0F;
      3'd5:    return 12'hF00;
      3'd6:    return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction
`else
  // RGB565 -> RGB444: keep R[4:1], G[5:2], B[4:1].
  function automatic logic [11:0] pixel_value(logic [6:0] hi, logic [7:0] lo);
    return {hi, lo[7], lo[4:1]};
  endfunction
`endif

  // Capture FSM with registered write port, done pulse and sticky overflow.
  // NOTE: reset is sampled on the clock edge (synchronous); every register here
  // uses non-blocking assignment so all next-state values come from the same
  // pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      phase   <= 1'b0;
      byte1   <= '0;
      row     <= '0;
      col     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      vsync_q <= cam.vsync;
      href_q  <= cam.href;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;

      case (state)
        IDLE: begin
          if (cam.init) state <= WAIT_FRAME;
        end

        WAIT_FRAME: begin
          if (vsync_fall) begin
            state <= CAPTURE;
            row   <= '0;
            col   <= '0;
            phase <= 1'b0;
            ovf_q <= 1'b0;
          end
        end

        CAPTURE: begin
          if (vsync_rise) begin
            // End of frame wins over any byte on the bus this cycle.
            done_q <= 1'b1;
            phase  <= 1'b0;
            state  <= cam.init ? WAIT_FRAME : IDLE;
          end else if (cam.href) begin
            if (!phase) begin
              byte1 <= {cam.px_data[7:4], cam.px_data[2:0]};
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (col != '1) col <= col + 1'b1;
              if (px_in_image) begin
                wr_q   <= 1'b1;
                addr_q <= AW'(row) * AW'(IMG_W) + AW'(col);
`ifdef CAM_TESTPAT_EN
                data_q <= DW'(pixel_value(col));
`else
                data_q <= DW'(pixel_value(byte1, cam.px_data));
`endif
              end else begin
                ovf_q <= 1'b1;
              end
            end
          end else if (href_fall) begin
            // A lone first byte at end of line is dropped with the phase reset.
            if (row != '1) row <= row + 1'b1;
            col   <= '0;
            phase <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign cam.mem_px_addr = addr_q;
  assign cam.mem_px_data = data_q;
  assign cam.px_wr       = wr_q;
  assign cam.done        = done_q;
  assign cam.overflow    = ovf_q;

endmodule
